// File: rtl/gray_pkg.sv
// Shared mode encoding, full-width Gray/binary conversions and decode slice bounds.
// Latency: none (types and constant/combinational helpers only).
// Backpressure: not applicable.
package gray_pkg;

   // Widest word the helper functions handle; callers zero-extend and truncate.
   localparam int GRAY_W = 64;

   typedef enum logic {
      GRAY_DEC = 1'b0,
      BIN_ENC  = 1'b1
   } gray_mode_e;

   typedef logic [GRAY_W-1:0] gray_word_t;

   // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: MSB copies through, every lower bit folds in the bit above it.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b[GRAY_W-1] = g[GRAY_W-1];
      for (int i = GRAY_W - 2; i >= 0; i--) begin
         b[i] = g[i] ^ b[i+1];
      end
      return b;
   endfunction

   // Bits resolved per decode stage, rounded up so every bit lands in some stage.
   function automatic int slice_bps(input int n, input int stages);
      return (n + stages - 1) / stages;
   endfunction

   // Top bit resolved by stage s; goes negative for trailing stages with nothing left to do.
   function automatic int slice_hi(input int n, input int stages, input int s);
      return n - 1 - s * slice_bps(n, stages);
   endfunction

   // Bottom bit resolved by stage s, clamped at bit 0.
   function automatic int slice_lo(input int n, input int stages, input int s);
      int lo;
      lo = n - (s + 1) * slice_bps(n, stages);
      return (lo < 0) ? 0 : lo;
   endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One pipeline slice: registers a beat and resolves binary bits HI..LO of a Gray decode.
// Latency: 1 cycle from accepting a beat to presenting it downstream.
// Backpressure: ready upstream = slice empty or downstream ready; held beat is frozen otherwise.
module gray_pipe_stage
   import gray_pkg::*;
#(
   parameter int N  = 4,
   parameter int HI = 3,
   parameter int LO = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_vld,
   output logic         o_rdy,
   input  logic         i_mode,
   input  logic [N-1:0] i_raw,
   input  logic [N-1:0] i_part,
   output logic         o_vld,
   input  logic         i_rdy,
   output logic         o_mode,
   output logic [N-1:0] o_raw,
   output logic [N-1:0] o_part
);

   logic         r_vld;
   logic         r_mode;
   logic [N-1:0] r_raw;
   logic [N-1:0] r_part;
   logic [N:0]   w_chain;
   logic [N-1:0] w_part;

   // Slice can take a new beat when empty or when its current beat leaves this cycle.
   assign o_rdy = !r_vld || i_rdy;

   // Resolve this slice MSB-first on top of the bits already resolved upstream;
   // bit N of the chain is a constant 0 so the word's MSB simply copies through.
   always_comb begin
      w_chain = {1'b0, i_part};
      if (i_mode == GRAY_DEC) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (i <= HI && i >= LO) begin
               w_chain[i] = i_raw[i] ^ w_chain[i+1];
            end
         end
      end
      w_part = w_chain[N-1:0];
   end

   // Advance whenever ready so bubbles collapse; the payload only follows a real beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_mode <= 1'b0;
         r_raw  <= '0;
         r_part <= '0;
      end else if (o_rdy) begin
         r_vld <= i_vld;
         if (i_vld) begin
            r_mode <= i_mode;
            r_raw  <= i_raw;
            r_part <= w_part;
         end
      end
   end

   assign o_vld  = r_vld;
   assign o_mode = r_mode;
   assign o_raw  = r_raw;
   assign o_part = r_part;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined per-beat Gray<->binary codec; decode XOR chain spread over STAGES slices.
// Latency: exactly STAGES cycles in both modes when the output is not stalled.
// Backpressure: full valid/ready chain; in_ready depends only on stage state and out_ready.
module gray_codec_pipe
   import gray_pkg::*;
#(
   parameter int N      = 4,   // 2 <= N <= GRAY_W
   parameter int STAGES = 1    // 1 <= STAGES <= N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_mode
);

   // Index 0 is the input side, index k+1 is the output of stage k.
   logic [STAGES:0]        w_vld;
   logic [STAGES:0]        w_rdy;
   logic [STAGES:0]        w_mode;
   logic [STAGES:0][N-1:0] w_raw;
   logic [STAGES:0][N-1:0] w_part;
   logic                   w_unused_raw;

   assign w_vld[0]  = in_valid;
   assign w_mode[0] = in_mode;
   assign w_raw[0]  = in_data;

   // Encode is finished before stage 0 registers it; decode starts from an empty partial word.
   assign w_part[0] = (in_mode == BIN_ENC) ? N'(bin2gray(gray_word_t'(in_data))) : '0;

   assign w_rdy[STAGES] = out_ready;
   assign in_ready      = w_rdy[0];

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      gray_pipe_stage #(
         .N  (N),
         .HI (slice_hi(N, STAGES, s)),
         .LO (slice_lo(N, STAGES, s))
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .i_vld  (w_vld[s]),
         .o_rdy  (w_rdy[s]),
         .i_mode (w_mode[s]),
         .i_raw  (w_raw[s]),
         .i_part (w_part[s]),
         .o_vld  (w_vld[s+1]),
         .i_rdy  (w_rdy[s+1]),
         .o_mode (w_mode[s+1]),
         .o_raw  (w_raw[s+1]),
         .o_part (w_part[s+1])
      );
   end

   // The Gray word leaving the last slice has no consumer.
   assign w_unused_raw = ^w_raw[STAGES];

   assign out_valid = w_vld[STAGES];
   assign out_mode  = w_mode[STAGES];
   assign out_data  = w_part[STAGES];

endmodule
